// File: rtl/seestuff_arb_pkg.sv
// seestuff_arb shared types: arbiter state, burst limit, grant index.
package seestuff_arb_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } arbState_t;

  // Widest burst the 4-bit burst counter can represent.
  localparam int BURST_LIMIT = 15;

  typedef logic [1:0] grantIdx_t;

endpackage

// File: rtl/seestuff_rr_pick.sv
// Round-robin pick: first set request bit after ptr, wrapping back to ptr.
module seestuff_rr_pick
  import seestuff_arb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  grantIdx_t          ptr,
  output grantIdx_t          idx,
  output logic               found
);

  grantIdx_t cand;

  always_comb begin
    idx   = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = grantIdx_t'((int'(ptr) + off) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/seestuff_arb.sv
// seestuff_arb: round-robin burst arbiter onto one registered rdy/vld output.
// Define SEESTUFF_ARB_STATS_EN to add per-requester grant_cnt counters.
module seestuff_arb
  import seestuff_arb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int DATA_W    = 5,
  parameter int BURST_MAX = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [NUM_REQ-1:0]        src_vld,
  input  logic [NUM_REQ*DATA_W-1:0] src_data,
  output logic [NUM_REQ-1:0]        src_rdy,
  output logic                      dst_vld,
  output logic [DATA_W-1:0]         dst_data,
  output logic [1:0]                dst_src,
  input  logic                      dst_rdy
`ifdef SEESTUFF_ARB_STATS_EN
  ,
  output logic [NUM_REQ*16-1:0]     grant_cnt
`endif
);

  localparam int BURST_EFF =
    (BURST_MAX > BURST_LIMIT) ? BURST_LIMIT : BURST_MAX;

  arbState_t  state, stateNxt;
  grantIdx_t  grant, grantNxt, pickIdx;
  logic [3:0] burstCnt, burstNxt;
  logic       accept, atLimit, fire;
  logic       anyVld, pickFound;

  logic [DATA_W-1:0] srcWord [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_word
    assign srcWord[i] = src_data[i*DATA_W +: DATA_W];
  end

  assign accept  = !dst_vld || dst_rdy;
  assign anyVld  = |src_vld;
  assign atLimit = (burstCnt == 4'(BURST_EFF));
  assign fire    = |(src_rdy & src_vld);

  // A full burst spends one cycle re-arbitrating with src_rdy low.
  always_comb begin
    src_rdy = '0;
    if (state == BUSY && en && accept && !atLimit)
      src_rdy[grant] = 1'b1;
  end

  seestuff_rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_pick (
    .req   (src_vld),
    .ptr   (grant),
    .idx   (pickIdx),
    .found (pickFound)
  );

  always_comb begin
    stateNxt = state;
    grantNxt = grant;
    burstNxt = burstCnt;
    unique case (state)
      IDLE: begin
        if (en && anyVld) begin
          stateNxt = BUSY;
          grantNxt = pickIdx;
          burstNxt = '0;
        end
      end
      BUSY: begin
        if (!en) begin
          stateNxt = IDLE;
          burstNxt = '0;
        end else if (atLimit || (accept && !src_vld[grant])) begin
          burstNxt = '0;
          if (pickFound) grantNxt = pickIdx;
          else           stateNxt = IDLE;
        end else if (fire) begin
          burstNxt = burstCnt + 4'd1;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= grantIdx_t'(NUM_REQ - 1);
      burstCnt <= '0;
    end else begin
      state    <= stateNxt;
      grant    <= grantNxt;
      burstCnt <= burstNxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dst_vld  <= 1'b0;
      dst_data <= '0;
      dst_src  <= '0;
    end else if (fire) begin
      dst_vld  <= 1'b1;
      dst_data <= srcWord[grant];
      dst_src  <= grant;
    end else if (dst_rdy) begin
      dst_vld  <= 1'b0;
    end
  end

`ifdef SEESTUFF_ARB_STATS_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        grant_cnt[i*16 +: 16] <= '0;
      else if (fire && grant == grantIdx_t'(i) &&
               grant_cnt[i*16 +: 16] != 16'hFFFF)
        grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_seestuff_arb.sv
// Scoreboard bench for seestuff_arb: directed cases plus random rounds
// checked against a transaction-level round-robin burst model.
module tb_seestuff_arb;

  localparam int NR = 3;
  localparam int DW = 5;
  localparam int BM = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic [NR-1:0] src_vld = '0;
  logic [NR*DW-1:0] src_data = '0;
  logic [NR-1:0] src_rdy;
  logic          dst_vld;
  logic [DW-1:0] dst_data;
  logic [1:0]    dst_src;
  logic          dst_rdy = 1'b0;
`ifdef SEESTUFF_ARB_STATS_EN
  logic [NR*16-1:0] grant_cnt;
`endif

  seestuff_arb #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .BURST_MAX (BM)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .src_vld  (src_vld),
    .src_data (src_data),
    .src_rdy  (src_rdy),
    .dst_vld  (dst_vld),
    .dst_data (dst_data),
    .dst_src  (dst_src),
    .dst_rdy  (dst_rdy)
`ifdef SEESTUFF_ARB_STATS_EN
    ,
    .grant_cnt (grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    src;
    logic [DW-1:0] data;
  } beat_t;

  beat_t         expQ[$];
  logic [DW-1:0] srcQ[NR][$];
  logic [DW-1:0] modelQ[NR][$];
  int            beatCyc[$];
  int            compared = 0;
  int            mismatched = 0;
  int            cyc = 0;
  int            lastG = NR - 1;
  logic          enVal = 1'b1;
  logic          rdyForce = 1'b1;
  logic          rdyRand = 1'b0;
  logic          monOff = 1'b0;
  logic [NR-1:0] hs = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    beat_t got, want;
    if (!rst && !monOff && dst_vld && dst_rdy) begin
      got.src  = dst_src;
      got.data = dst_data;
      compared++;
      beatCyc.push_back(cyc);
      if (expQ.size() == 0) begin
        mismatched++;
        $display("FAIL beat: got src=%0d data=%h, required no beat",
                 got.src, got.data);
      end else begin
        want = expQ.pop_front();
        if (got !== want) begin
          mismatched++;
          $display("FAIL beat: got src=%0d data=%h, required src=%0d data=%h",
                   got.src, got.data, want.src, want.data);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic drive();
    en      = enVal;
    dst_rdy = rdyRand ? 1'($urandom_range(0, 1)) : rdyForce;
    for (int i = 0; i < NR; i++) begin
      src_vld[i] = (srcQ[i].size() != 0);
      src_data[i*DW +: DW] = (srcQ[i].size() != 0) ? srcQ[i][0] : '0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++)
      if (hs[i] && srcQ[i].size() != 0) void'(srcQ[i].pop_front());
    drive();
    @(negedge clk);
    hs = src_vld & src_rdy;
  endtask

  task automatic issue(input int s, input logic [DW-1:0] d);
    srcQ[s].push_back(d);
    modelQ[s].push_back(d);
  endtask

  // Round robin from lastG+1, each requester taking min(BM, pending) beats.
  task automatic runModel();
    int    g;
    bit    any;
    beat_t b;
    any = 1'b1;
    while (any) begin
      any = 1'b0;
      for (int i = 0; i < NR; i++) if (modelQ[i].size() != 0) any = 1'b1;
      if (any) begin
        g = lastG;
        for (int off = NR; off >= 1; off--)
          if (modelQ[(lastG + off) % NR].size() != 0) g = (lastG + off) % NR;
        for (int k = 0; k < BM && modelQ[g].size() != 0; k++) begin
          b.src  = 2'(g);
          b.data = modelQ[g].pop_front();
          expQ.push_back(b);
        end
        lastG = g;
      end
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      cycle();
      n++;
    end
    repeat (3) cycle();
    check({name, " left"}, 32'(expQ.size()), 32'd0);
  endtask

  initial begin
    int n, cnt;
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst dst_vld", 32'(dst_vld), 32'd0);
    check("rst src_rdy", 32'(src_rdy), 32'd0);
    check("rst dst_data", 32'(dst_data), 32'd0);
    check("rst dst_src", 32'(dst_src), 32'd0);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) issue(0, 5'(k + 1));
    for (int k = 0; k < 4; k++) issue(1, 5'(k + 17));
    for (int k = 0; k < 4; k++) issue(2, 5'(k + 25));
    runModel();
    beatCyc.delete();
    drain("rr", 100);
    check("rr beats", 32'(beatCyc.size()), 32'd16);
    if (beatCyc.size() == 16)
      check("rr span", 32'(beatCyc[15] - beatCyc[0]), 32'd18);

    for (int k = 1; k <= 6; k++) issue(0, 5'(k));
    runModel();
    beatCyc.delete();
    drain("solo", 60);
    check("solo beats", 32'(beatCyc.size()), 32'd6);
    if (beatCyc.size() == 6) begin
      check("solo bubble", 32'(beatCyc[4] - beatCyc[3]), 32'd2);
      check("solo span", 32'(beatCyc[5] - beatCyc[0]), 32'd6);
    end

    rdyForce = 1'b0;
    issue(1, 5'h11);
    issue(1, 5'h12);
    issue(1, 5'h13);
    runModel();
    n = 0;
    while (!dst_vld && n < 10) begin
      cycle();
      n++;
    end
    check("stall vld", 32'(dst_vld), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("stall data", 32'(dst_data), 32'h11);
      check("stall src_rdy", 32'(src_rdy), 32'd0);
      cycle();
    end
    rdyForce = 1'b1;
    drain("stall", 40);

    for (int k = 0; k < 6; k++) issue(1, 5'(k + 10));
    for (int k = 0; k < 2; k++)
      expQ.push_back(beat_t'{2'd1, modelQ[1].pop_front()});
    n = 0;
    cnt = 0;
    while (cnt < 2 && n < 20) begin
      cycle();
      if (hs[1]) cnt++;
      n++;
    end
    enVal = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("en low src_rdy", 32'(src_rdy), 32'd0);
    end
    check("en low drained", 32'(expQ.size()), 32'd0);
    check("en low dst_vld", 32'(dst_vld), 32'd0);
    for (int k = 0; k < 3; k++) issue(2, 5'(k + 21));
    lastG = 1;
    runModel();
    enVal = 1'b1;
    drain("en", 60);

    rdyForce = 1'b0;
    srcQ[0].push_back(5'h1E);
    n = 0;
    while (!dst_vld && n < 10) begin
      cycle();
      n++;
    end
    check("pre-rst vld", 32'(dst_vld), 32'd1);
    rst = 1'b1;
    for (int i = 0; i < NR; i++) begin
      srcQ[i].delete();
      modelQ[i].delete();
    end
    expQ.delete();
    hs = '0;
    drive();
    @(posedge clk);
    @(negedge clk);
    check("mid-rst dst_vld", 32'(dst_vld), 32'd0);
    check("mid-rst src_rdy", 32'(src_rdy), 32'd0);
    rst = 1'b0;
    lastG = NR - 1;
    rdyForce = 1'b1;
    issue(0, 5'h03);
    issue(0, 5'h04);
    issue(1, 5'h05);
    issue(1, 5'h06);
    runModel();
    drain("post-rst", 40);

    rdyRand = 1'b1;
    for (int r = 0; r < 25; r++) begin
      for (int i = 0; i < NR; i++) begin
        n = $urandom_range(0, 9);
        for (int k = 0; k < n; k++) issue(i, 5'($urandom));
      end
      runModel();
      drain("rand", 400);
      repeat (2) cycle();
    end

`ifdef SEESTUFF_ARB_STATS_EN
    rdyRand = 1'b0;
    rdyForce = 1'b1;
    monOff = 1'b1;
    for (int k = 0; k < 70000; k++) srcQ[0].push_back(5'(k));
    n = 0;
    while (srcQ[0].size() != 0 && n < 90000) begin
      cycle();
      n++;
    end
    repeat (3) cycle();
    check("stats sat", 32'(grant_cnt[15:0]), 32'h0000FFFF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
